rng_word_collector: RTL and testbench
=====================================

Name: rng_word_collector

Overview:
- Downstream consumer of the serial LFSR random-bit stage.
- Drives the LFSR advance enable, samples its output bit, and packs bits into WORD_WIDTH-bit random words.
- Buffers words in a small FIFO for the processor's memory-mapped RNG register, which pops them with a read strobe.
- Stalls the LFSR when the buffer is full, so no generated word is lost.

Parameters:
WORD_WIDTH, 16, bits per output word (processor datapath width); valid range 2..32
DEPTH, 2, FIFO entries; power of two, 2..8
SKIP_WIDTH, 4, width of the runtime skip-count input

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
bit_in  input  1  LFSR output bit (its data[0]); valid every cycle
lfsr_en  output  1  LFSR advance enable; bit_in is consumed on every clk edge where lfsr_en=1
skip_count  input  SKIP_WIDTH  raw LFSR bits discarded between words; latched at word completion
rd_en  input  1  pop strobe from bus interface
word_out  output  WORD_WIDTH  FIFO head word; 0 when empty
word_valid  output  1  FIFO non-empty
fill_level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. On assertion, immediately and regardless of clk:
  - state=COLLECT, shift register=0, bit counter=0, skip counter=0, FIFO emptied;
  - word_valid=0, word_out=0, fill_level=0, lfsr_en=0 while rst=1.
- Reset mid-word discards the partial word. Reset mid-skip abandons the skip.
- First edge after deassertion starts collecting.
- Shift rule: shreg <= {shreg[WORD_WIDTH-2:0], bit_in}. The first accepted bit ends up as the word's MSB.
- State COLLECT:
  - lfsr_en=1; each edge accepts one bit.
  - On the WORD_WIDTH-th accepted bit, the completed word {shreg[WORD_WIDTH-2:0], bit_in} is pushed into the FIFO on that same edge, bit counter clears, and skip_count is latched.
  - Next state: SKIP if latched skip_count≠0; else STALL if the FIFO is full after this push/pop; else COLLECT.
- State SKIP:
  - lfsr_en=1; bit_in is ignored; skip counter decrements each edge.
  - After exactly skip_count edges: STALL if the FIFO is full, else COLLECT.
- State STALL:
  - lfsr_en=0.
  - Moves to COLLECT on the edge where fill_level<DEPTH, or a pop occurs (rd_en=1, word_valid=1).
  - lfsr_en is combinational: high in STALL only in that exit cycle. No bit is accepted that cycle; acceptance resumes next cycle.
- COLLECT never starts a word it cannot store: entry requires a free slot, and at most one word completes per WORD_WIDTH edges.
- Latency: with an empty FIFO and skip_count=0, the first word_valid rises after edge WORD_WIDTH post-reset. Throughput is one word per WORD_WIDTH+skip_count cycles.
- FIFO:
  - First-word-fall-through; word_out is registered head data.
  - Pop on rd_en & word_valid; rd_en while empty is ignored with no underflow.
  - Simultaneous push and pop: allowed at any level including full; occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- skip_count changes are sampled only at word completion. Changes mid-skip do not affect the current skip.

Optional Feature:
- Macro RNG_DEBIAS_EN.
- When defined, COLLECT applies von Neumann debiasing:
  - raw bits are taken in pairs (a, then b);
  - a≠b: accept a;
  - a==b: discard both.
- Pair phase resets at reset, at word completion, and on leaving SKIP/STALL.
- Only accepted bits count toward WORD_WIDTH; SKIP counts raw bits; lfsr_en timing is unchanged.
- When undefined: every raw bit in COLLECT is accepted and no pair logic is synthesized.

Decomposition:
- Package rng_pkg holds:
  - state encoding constants ST_COLLECT=2'd0, ST_SKIP=2'd1, ST_STALL=2'd2;
  - default width constants.
- Sub-module rng_fifo: parameterized WORD_WIDTH/DEPTH FWFT FIFO with push, pop, full, empty, level.
- The FSM, shift register and counters stay in the top module.

Test Plan:
1. Reset then bit_in=1010… alternating, skip_count=0, rd_en=0 → word_valid rises after edge 16 with word_out=16'hAAAA. Second word 16'hAAAA at edge 32. lfsr_en falls (STALL) after edge 32, with fill_level=2.
2. From the full state of test 1, pulse rd_en one cycle → fill_level=1. Collection resumes and lfsr_en is high exactly 16 accepted cycles before the next stall. Popped order is FIFO.
3. skip_count=3, bit_in driven from a 32-bit LFSR reference model → each word equals model bits [n..n+15], with bits n+16..n+18 absent from the output stream.
4. Assert rst asynchronously (between edges) after 9 accepted bits → word_valid, fill_level and lfsr_en drop before the next edge. Post-reset first word contains only post-reset bits.
5. Full FIFO, rd_en held high continuously, skip_count=0 → simultaneous push/pop at completion edges. fill_level never exceeds 2, no word is lost or duplicated versus the model.
6. RNG_DEBIAS_EN defined, raw pairs 01,00,10,11 repeated → accepted bits 0,1 repeated; first word 16'h5555 after 64 raw cycles.

Source files
------------

// File: rtl/rng_pkg.sv
// rng_pkg
//   Shared definitions for the RNG word collector slice.
//   - state_e     : collector FSM state encoding (COLLECT / SKIP / STALL)
//   - DEF_*       : default widths used by the collector and its FIFO
package rng_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SKIP    = 2'd1,
        ST_STALL   = 2'd2
    } state_e;

    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_DEPTH      = 2;
    localparam int DEF_SKIP_WIDTH = 4;

endpackage

// File: rtl/rng_fifo.sv
// rng_fifo
//   First-word-fall-through FIFO holding completed random words.
//   The head entry is presented straight from the storage registers, so
//   head_o is registered data and reads 0 while the FIFO is empty.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   push_i       : write push_data_i (honoured when not full, or full with a pop)
//   push_data_i  : word to store
//   pop_i        : remove head entry (ignored while empty)
//   head_o       : current head word, 0 when empty
//   full_o       : occupancy equals DEPTH
//   empty_o      : occupancy is zero
//   level_o      : current occupancy
module rng_fifo
    import rng_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [WORD_WIDTH-1:0]   push_data_i,
    input  logic                    pop_i,
    output logic [WORD_WIDTH-1:0]   head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/rng_word_collector.sv
// rng_word_collector
//   Drives the advance enable of the serial LFSR stage, packs its output
//   bits MSB-first into WORD_WIDTH-bit words, optionally discards a run of
//   raw bits between words, and buffers words in a FWFT FIFO that the
//   processor pops through its RNG register. When the FIFO is full the LFSR
//   is stalled so no generated word is ever dropped.
// Configuration macro:
//   RNG_DEBIAS_EN : von Neumann debiasing of raw bits while collecting.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   bit_in      : LFSR output bit, valid every cycle
//   lfsr_en     : LFSR advance enable; bit_in consumed on edges where high
//   skip_count  : raw bits discarded between words, latched at word completion
//   rd_en       : pop strobe from the bus interface
//   word_out    : FIFO head word, 0 when empty
//   word_valid  : FIFO non-empty
//   fill_level  : FIFO occupancy
module rng_word_collector
    import rng_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int SKIP_WIDTH = DEF_SKIP_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bit_in,
    output logic                    lfsr_en,
    input  logic [SKIP_WIDTH-1:0]   skip_count,
    input  logic                    rd_en,
    output logic [WORD_WIDTH-1:0]   word_out,
    output logic                    word_valid,
    output logic [$clog2(DEPTH):0]  fill_level
);

    localparam int CNT_W = $clog2(WORD_WIDTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_WIDTH - 1);
    localparam logic [LVL_W-1:0] ONE_BELOW  = LVL_W'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
    logic [SKIP_WIDTH-1:0] skipcnt_q, skipcnt_d;

    logic accept;
    logic acc_bit;
    logic word_done;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic full_after_push;

`ifdef RNG_DEBIAS_EN
    logic phase_q, phase_d;
    logic first_q, first_d;
`endif

    assign word_valid = !fifo_empty;
    assign pop        = rd_en && word_valid;

    // Occupancy after a completion edge, accounting for a pop on that same edge.
    assign full_after_push = pop ? fifo_full : (fill_level == ONE_BELOW);

    // Next-state, shift/counter updates and the LFSR enable. The STALL exit
    // cycle raises lfsr_en without accepting the bit, so acceptance resumes
    // one cycle later from COLLECT.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        skipcnt_d = skipcnt_q;
        lfsr_en   = 1'b0;
        accept    = 1'b0;
        acc_bit   = bit_in;
        word_done = 1'b0;
`ifdef RNG_DEBIAS_EN
        phase_d   = phase_q;
        first_d   = first_q;
`endif

        case (state_q)
            ST_COLLECT: begin
                lfsr_en = 1'b1;
`ifdef RNG_DEBIAS_EN
                // First bit of a pair is parked; the pair yields it only if the bits differ.
                if (!phase_q) begin
                    first_d = bit_in;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (first_q != bit_in) begin
                        accept  = 1'b1;
                        acc_bit = first_q;
                    end
                end
`else
                accept  = 1'b1;
                acc_bit = bit_in;
`endif
                if (accept) begin
                    shreg_d = {shreg_q[WORD_WIDTH-2:0], acc_bit};
                    if (bitcnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        bitcnt_d  = '0;
                        skipcnt_d = skip_count;
                        if (skip_count != '0) begin
                            state_d = ST_SKIP;
                        end else if (full_after_push) begin
                            state_d = ST_STALL;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end

            ST_SKIP: begin
                lfsr_en   = 1'b1;
                skipcnt_d = skipcnt_q - 1'b1;
`ifdef RNG_DEBIAS_EN
                phase_d   = 1'b0;
`endif
                if (skipcnt_q <= SKIP_WIDTH'(1)) begin
                    state_d = (fifo_full && !pop) ? ST_STALL : ST_COLLECT;
                end
            end

            ST_STALL: begin
`ifdef RNG_DEBIAS_EN
                phase_d = 1'b0;
`endif
                if (!fifo_full || pop) begin
                    lfsr_en = 1'b1;
                    state_d = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        // The LFSR must not advance while the collector is held in reset.
        if (rst) begin
            lfsr_en = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_COLLECT;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            skipcnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            skipcnt_q <= skipcnt_d;
        end
    end

`ifdef RNG_DEBIAS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            first_q <= first_d;
        end
    end
`endif

    // The completed word is pushed on the same edge its last bit is accepted.
    rng_fifo #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (word_done),
        .push_data_i (shreg_d),
        .pop_i       (pop),
        .head_o      (word_out),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fill_level)
    );

endmodule

// File: tb/tb_rng_word_collector.sv
// tb_rng_word_collector
//   Directed bench for rng_word_collector with default parameters
//   (WORD_WIDTH=16, DEPTH=2, SKIP_WIDTH=4). The raw LFSR bit stream is held
//   in an array; the bench advances its read index on every edge where the
//   DUT raised lfsr_en, and expected words are sliced from that array.
//   Builds with RNG_DEBIAS_EN run the debiasing scenario instead of the
//   plain-collection scenarios.
module tb_rng_word_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        lfsr_en;
    logic [3:0]  skip_count;
    logic        rd_en;
    logic [15:0] word_out;
    logic        word_valid;
    logic [1:0]  fill_level;

    int errors = 0;
    int checks = 0;

    logic        raw [0:511];
    int          rawIdx;
    logic [15:0] popped [$];

    rng_word_collector #(
        .WORD_WIDTH (16),
        .DEPTH      (2),
        .SKIP_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .lfsr_en    (lfsr_en),
        .skip_count (skip_count),
        .rd_en      (rd_en),
        .word_out   (word_out),
        .word_valid (word_valid),
        .fill_level (fill_level)
    );

    // 10 ns period clock
    always #5 clk = ~clk;

    // Hard stop in case something wedges the stimulus
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Expected word built from 16 consecutive raw bits, first bit as MSB
    function automatic logic [15:0] rawWord(input int start);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w = {w[14:0], raw[start + i]};
        end
        return w;
    endfunction

    task automatic fill_alternating();
        for (int i = 0; i < 512; i++) raw[i] = (i % 2 == 0);
    endtask

    // Galois LFSR reference stream, taps x^32+x^22+x^2+x+1
    task automatic fill_lfsr(input logic [31:0] seed);
        logic [31:0] s;
        s = seed;
        for (int i = 0; i < 512; i++) begin
            raw[i] = s[0];
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        end
    endtask

    task automatic fill_debias_pattern();
        logic [7:0] pat;
        pat = 8'b0100_1011;
        for (int i = 0; i < 512; i++) raw[i] = pat[7 - (i % 8)];
    endtask

    // One clock: sample at the falling edge, then step the LFSR model just
    // after the rising edge if the DUT asked for an advance.
    task automatic tick();
        logic en;
        @(negedge clk);
        en = lfsr_en;
        if (rd_en && word_valid) popped.push_back(word_out);
        @(posedge clk);
        #1;
        if (en) rawIdx++;
        bit_in = raw[rawIdx];
    endtask

    // Synchronous-looking reset pulse; leaves time at posedge+1 with rst low
    task automatic do_reset();
        rst = 1'b1;
        popped.delete();
        rawIdx = 0;
        bit_in = raw[0];
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        fill_alternating();
        rd_en      = 1'b0;
        skip_count = 4'd0;
        bit_in     = 1'b1;
        rst        = 1'b1;
        #2;
        if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", word_valid); end
        checks++;
        if (word_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_word: got %h expected 0000", word_out); end
        checks++;
        if (fill_level !== 2'd0) begin errors++; $display("[TB] FAIL reset_fill: got %0d expected 0", fill_level); end
        checks++;
        if (lfsr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_lfsr_en: got %b expected 0", lfsr_en); end
        checks++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_to_stall();
        fill_alternating();
        skip_count = 4'd0;
        rd_en      = 1'b0;
        do_reset();
        repeat (15) tick();
        if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL early_valid: got %b expected 0 after 15 edges", word_valid); end
        checks++;
        tick();
        if (word_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b expected 1 after 16 edges", word_valid); end
        checks++;
        if (word_out !== 16'hAAAA) begin errors++; $display("[TB] FAIL first_word: got %h expected aaaa", word_out); end
        checks++;
        if (fill_level !== 2'd1) begin errors++; $display("[TB] FAIL first_fill: got %0d expected 1", fill_level); end
        checks++;
        repeat (16) tick();
        if (fill_level !== 2'd2) begin errors++; $display("[TB] FAIL full_fill: got %0d expected 2", fill_level); end
        checks++;
        if (lfsr_en !== 1'b0) begin errors++; $display("[TB] FAIL stall_en: got %b expected 0", lfsr_en); end
        checks++;
        if (word_out !== 16'hAAAA) begin errors++; $display("[TB] FAIL full_head: got %h expected aaaa", word_out); end
        checks++;
        if (rawIdx !== 32) begin errors++; $display("[TB] FAIL full_raw_count: got %0d expected 32", rawIdx); end
        checks++;
    endtask

    task automatic test_pop_resume();
        int cnt;
        rd_en = 1'b1;
        #1;
        if (lfsr_en !== 1'b1) begin errors++; $display("[TB] FAIL stall_exit_en: got %b expected 1", lfsr_en); end
        checks++;
        tick();
        rd_en = 1'b0;
        #1;
        if (fill_level !== 2'd1) begin errors++; $display("[TB] FAIL after_pop_fill: got %0d expected 1", fill_level); end
        checks++;
        cnt = 0;
        while (lfsr_en === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        if (cnt !== 16) begin errors++; $display("[TB] FAIL resume_cycles: got %0d expected 16", cnt); end
        checks++;
        if (fill_level !== 2'd2) begin errors++; $display("[TB] FAIL refill: got %0d expected 2", fill_level); end
        checks++;
        if (rawIdx !== 49) begin errors++; $display("[TB] FAIL resume_raw_count: got %0d expected 49", rawIdx); end
        checks++;
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        #1;
        if (popped.size() !== 3) begin
            errors++; $display("[TB] FAIL pop_count: got %0d expected 3", popped.size());
        end else begin
            if (popped[0] !== 16'hAAAA) begin errors++; $display("[TB] FAIL pop0: got %h expected aaaa", popped[0]); end
            if (popped[1] !== 16'hAAAA) begin errors++; $display("[TB] FAIL pop1: got %h expected aaaa", popped[1]); end
            if (popped[2] !== 16'h5555) begin errors++; $display("[TB] FAIL pop2: got %h expected 5555", popped[2]); end
            checks += 3;
        end
        checks++;
        if (fill_level !== 2'd0) begin errors++; $display("[TB] FAIL drained_fill: got %0d expected 0", fill_level); end
        checks++;
    endtask

    task automatic test_skip();
        int n;
        fill_lfsr(32'hACE1_2357);
        skip_count = 4'd3;
        rd_en      = 1'b1;
        do_reset();
        n = 0;
        while (popped.size() < 4 && n < 200) begin
            tick();
            n++;
        end
        if (popped.size() !== 4) begin
            errors++; $display("[TB] FAIL skip_count_words: got %0d expected 4", popped.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (popped[k] !== rawWord(19 * k)) begin
                    errors++;
                    $display("[TB] FAIL skip_word%0d: got %h expected %h", k, popped[k], rawWord(19 * k));
                end
                checks++;
            end
        end
        checks++;
        rd_en      = 1'b0;
        skip_count = 4'd0;
    endtask

    task automatic test_async_reset();
        fill_lfsr(32'h1357_9BDF);
        skip_count = 4'd0;
        rd_en      = 1'b0;
        do_reset();
        repeat (25) tick();
        if (fill_level !== 2'd1) begin errors++; $display("[TB] FAIL pre_reset_fill: got %0d expected 1", fill_level); end
        checks++;
        #3;
        rst = 1'b1;
        #1;
        if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid: got %b expected 0", word_valid); end
        checks++;
        if (fill_level !== 2'd0) begin errors++; $display("[TB] FAIL async_fill: got %0d expected 0", fill_level); end
        checks++;
        if (lfsr_en !== 1'b0) begin errors++; $display("[TB] FAIL async_en: got %b expected 0", lfsr_en); end
        checks++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (16) tick();
        if (word_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_valid: got %b expected 1", word_valid); end
        checks++;
        if (word_out !== rawWord(25)) begin errors++; $display("[TB] FAIL post_reset_word: got %h expected %h", word_out, rawWord(25)); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int maxFill;
        logic [15:0] expWords [5];
        fill_lfsr(32'h0BAD_F00D);
        skip_count = 4'd0;
        rd_en      = 1'b0;
        do_reset();
        repeat (32) tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        repeat (15) tick();
        rd_en = 1'b1;
        tick();
        if (fill_level !== 2'd1) begin errors++; $display("[TB] FAIL simul_fill: got %0d expected 1", fill_level); end
        checks++;
        if (word_out !== rawWord(33)) begin errors++; $display("[TB] FAIL simul_head: got %h expected %h", word_out, rawWord(33)); end
        checks++;
        maxFill = 0;
        repeat (40) begin
            tick();
            if (int'(fill_level) > maxFill) maxFill = int'(fill_level);
        end
        rd_en = 1'b0;
        if (maxFill > 2) begin errors++; $display("[TB] FAIL max_fill: got %0d expected at most 2", maxFill); end
        checks++;
        expWords[0] = rawWord(0);
        expWords[1] = rawWord(16);
        expWords[2] = rawWord(33);
        expWords[3] = rawWord(49);
        expWords[4] = rawWord(65);
        if (popped.size() !== 5) begin
            errors++; $display("[TB] FAIL b2b_count: got %0d expected 5", popped.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (popped[k] !== expWords[k]) begin
                    errors++;
                    $display("[TB] FAIL b2b_word%0d: got %h expected %h", k, popped[k], expWords[k]);
                end
                checks++;
            end
        end
        checks++;
    endtask

    task automatic test_debias();
        fill_debias_pattern();
        skip_count = 4'd0;
        rd_en      = 1'b0;
        do_reset();
        repeat (63) tick();
        if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL debias_early: got %b expected 0", word_valid); end
        checks++;
        tick();
        if (word_valid !== 1'b1) begin errors++; $display("[TB] FAIL debias_valid: got %b expected 1", word_valid); end
        checks++;
        if (word_out !== 16'h5555) begin errors++; $display("[TB] FAIL debias_word: got %h expected 5555", word_out); end
        checks++;
    endtask

    initial begin
        rst        = 1'b1;
        rd_en      = 1'b0;
        skip_count = 4'd0;
        bit_in     = 1'b0;
        rawIdx     = 0;
        test_reset();
`ifdef RNG_DEBIAS_EN
        test_debias();
`else
        test_fill_to_stall();
        test_pop_resume();
        test_skip();
        test_async_reset();
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
